// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, Hi/Lo
// enable codes, FSM encoding and operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5
  } op_t;

  typedef enum logic [3:0] {
    EN_NONE = 4'd0,
    EN_MULT = 4'd1,
    EN_DIV  = 4'd3,
    EN_MADD = 4'd4,
    EN_MSUB = 4'd5
  } en_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SIGN,
    ST_WRITE
  } state_t;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_MSUB;
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic en_t op_enable(input logic [2:0] op);
    case (op)
      OP_MULT, OP_MULTU: return EN_MULT;
      OP_DIV, OP_DIVU:   return EN_DIV;
      OP_MADD:           return EN_MADD;
      OP_MSUB:           return EN_MSUB;
      default:           return EN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
);
  logic               Start;
  logic [2:0]         Op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] Product;
  logic [3:0]         enable;
  logic               Busy;
  logic               Done;

  modport master (
    output Start, Op, A, B,
    input  Product, enable, Busy, Done
  );

  modport slave (
    input  Start, Op, A, B,
    output Product, enable, Busy, Done
  );
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide, on a {hi,lo} double-width accumulator.
module mdu_step import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Shifted remainder can reach WIDTH+1 bits, so the trial keeps the bit
    // about to leave the top of the accumulator.
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    q_bit = ~trial[WIDTH];
    if (is_div)
      acc_next = {(q_bit ? trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]),
                  acc[WIDTH-2:0], q_bit};
    else
      acc_next = {sum, acc[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine producing the {Hi,Lo} Product and a
// one-cycle Hi/Lo write command per accepted operation.
module mult_div_unit import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic            Clk,
  input logic            Reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [2:0]         op_r;
  logic               s_a;
  logic               s_b;
  logic               b_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               q_bit;
  logic               is_div;
  logic               div_in;
  logic               neg_a;
  logic               neg_b;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_div = op_is_div(op_r);
  assign div_in = op_is_div(bus.Op);
  assign neg_a  = op_signed(bus.Op) & bus.A[WIDTH-1];
  assign neg_b  = op_signed(bus.Op) & bus.B[WIDTH-1];
  assign quo    = acc[WIDTH-1:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  // Sign fixup of the magnitude result; divide-by-zero bypasses it entirely.
  always_comb begin
    result = acc;
    if (is_div) begin
      if (b_zero)
        result = {a_raw, {WIDTH{1'b1}}};
      else
        result = {(s_a ? -rem : rem), ((s_a ^ s_b) ? -quo : quo)};
    end else if (s_a ^ s_b) begin
      result = -acc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      bus.Product <= '0;
      bus.enable  <= EN_NONE;
      bus.Busy    <= 1'b0;
      bus.Done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.Start && op_valid(bus.Op)) begin
            op_r     <= bus.Op;
            s_a      <= neg_a;
            s_b      <= neg_b;
            b_zero   <= (bus.B == '0);
            a_raw    <= bus.A;
            opnd     <= div_in ? mag(bus.B, neg_b) : mag(bus.A, neg_a);
            acc      <= {{WIDTH{1'b0}},
                         (div_in ? mag(bus.A, neg_a) : mag(bus.B, neg_b))};
            count    <= '0;
            bus.Busy <= 1'b1;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc   <= is_div ? {acc_next[2*WIDTH-1:1], q_bit} : acc_next;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1))
            state <= ST_SIGN;
        end
        ST_SIGN: begin
          bus.Product <= result;
          bus.enable  <= op_enable(op_r);
          bus.Done    <= 1'b1;
          state       <= ST_WRITE;
        end
        ST_WRITE: begin
          bus.enable <= EN_NONE;
          bus.Done   <= 1'b0;
          bus.Busy   <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic/latency model, one per-cycle compare
// process, and directed vectors with literal expected results.
module tb_mult_div_unit;

  logic Clk = 1'b0;
  logic Reset;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  logic chk_on = 1'b0;

  // Model state
  int          m_left = 0;
  logic        m_busy, m_done;
  logic [3:0]  m_en, m_code;
  logic [63:0] m_prod, m_res;

  // Literal expectations from the directed stimulus
  logic [63:0] lit_prod = '0;
  logic [3:0]  lit_en = '0;
  int          lit_edge = -1;
  logic        lit_rst = 1'b0;
  int          quiet_start = 1000000;
  int          quiet_end = -1;

  function automatic logic [63:0] exp_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: r = 64'(sa * sb);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] exp_code(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 4'd1;
      3'd2, 3'd3: return 4'd3;
      3'd4:       return 4'd4;
      3'd5:       return 4'd5;
      default:    return 4'd0;
    endcase
  endfunction

  // Operation-level model: an accepted op occupies 34 further edges and
  // presents its result on the last busy one.
  always @(posedge Clk) begin
    edge_n++;
    if (Reset) begin
      m_left = 0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_en   = 4'd0;
      m_prod = 64'd0;
    end else if (m_left > 0) begin
      m_left--;
      m_busy = (m_left > 0);
      m_done = (m_left == 1);
      m_en   = (m_left == 1) ? m_code : 4'd0;
      if (m_left == 1) m_prod = m_res;
    end else if (bus.Start && bus.Op <= 3'd5) begin
      m_left = 34;
      m_busy = 1'b1;
      m_res  = exp_result(bus.Op, bus.A, bus.B);
      m_code = exp_code(bus.Op);
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h, expected %h", nm, edge_n, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      check("busy", 64'(bus.Busy), 64'(m_busy));
      check("done", 64'(bus.Done), 64'(m_done));
      check("enable", 64'(bus.enable), 64'(m_en));
      check("product", bus.Product, m_prod);
      if (lit_rst) begin
        check("rst_product", bus.Product, 64'd0);
        check("rst_enable", 64'(bus.enable), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
      end
      if (lit_en != 4'd0 && edge_n == lit_edge) begin
        check("lit_done", 64'(bus.Done), 64'd1);
        check("lit_enable", 64'(bus.enable), 64'(lit_en));
        check("lit_product", bus.Product, lit_prod);
      end
      if (edge_n >= quiet_start && edge_n <= quiet_end) begin
        check("quiet_busy", 64'(bus.Busy), 64'd0);
        check("quiet_enable", 64'(bus.enable), 64'd0);
        check("quiet_done", 64'(bus.Done), 64'd0);
      end
    end
  end

  // Start is presented in cycle 0; loop iteration k runs in cycle k.
  // quiet_from > 0 demands Busy/enable/Done low from that cycle through 40.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] lp,
                        input logic [3:0] le, input int len,
                        input int poke, input int rst_at,
                        input int quiet_from);
    @(posedge Clk); #1;
    lit_en      = 4'd0;
    quiet_start = 1000000;
    bus.Start   = 1'b1;
    bus.Op      = op;
    bus.A       = a;
    bus.B       = b;
    for (int k = 1; k <= len; k++) begin
      @(posedge Clk); #1;
      if (k == 1) begin
        lit_prod = lp;
        lit_edge = edge_n + 33;
        lit_en   = le;
        if (quiet_from > 0) begin
          quiet_start = edge_n + quiet_from - 1;
          quiet_end   = edge_n + 39;
        end
      end
      bus.Start = (k == poke);
      if (k == poke) begin
        bus.Op = 3'd1;
        bus.A  = 32'h12345678;
        bus.B  = 32'h9ABCDEF0;
      end
      Reset = (k == rst_at);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset  = 1'b0;
    chk_on = 1'b1;
    lit_rst = 1'b1;
    @(posedge Clk); #1;
    lit_rst = 1'b0;

    run_op(3'd0, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 4'd1, 40, 0, 0, 0);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 4'd1, 34, 0, 0, 0);
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 4'd3, 40, 0, 0, 0);
    run_op(3'd3, 32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF, 4'd3, 40, 0, 0, 0);
    run_op(3'd4, 32'h00000005, 32'h00000006, 64'h00000000_0000001E, 4'd4, 40, 0, 0, 0);
    run_op(3'd5, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, 4'd5, 40, 0, 0, 0);
    run_op(3'd0, 32'h00000005, 32'h00000006, 64'h00000000_0000001E, 4'd1, 40, 5, 0, 0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 4'd3, 40, 0, 0, 0);
    run_op(3'd3, 32'h00000064, 32'h00000007, 64'h00000002_0000000E, 4'd3, 40, 0, 0, 0);
    run_op(3'd2, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 4'd3, 40, 0, 0, 0);
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, 4'd3, 40, 0, 0, 0);
    run_op(3'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 4'd1, 40, 0, 0, 0);
    run_op(3'd1, 32'h00000003, 32'h00000004, 64'h0, 4'd0, 40, 0, 10, 11);
    run_op(3'd6, 32'h00000003, 32'h00000004, 64'h0, 4'd0, 40, 0, 0, 1);
    run_op(3'd0, 32'h00000002, 32'h00000003, 64'h00000000_00000006, 4'd1, 40, 0, 0, 0);

    @(posedge Clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
